// File: rtl/game_screen_ctrl.sv
// Game screen sequencer: idle / play / game-over / victory / restart, with frame-aligned overlays.
// Optional overlay blinking is enabled by defining GAME_SCREEN_BLINK_EN.
module game_screen_ctrl #(
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 30
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic start_btn,
    input  logic collision,
    input  logic win,
    output logic game_run,
    output logic game_over,
    output logic victory,
    output logic snake_rst,
    output logic hold_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        OVER    = 3'd2,
        WIN     = 3'd3,
        RESTART = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);

    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $error("HOLD_FRAMES out of range 1..255");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
        $error("BLINK_FRAMES out of range 1..255");
    end

    state_t     state_reg;
    logic [7:0] frame_cnt_reg;
    logic       vsync_reg;
    logic       frame_tick;
    logic       in_end;
    logic       blink_phase;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_reg <= 1'b0;
        end else begin
            vsync_reg <= vsync_in;
        end
    end

    assign frame_tick = vsync_in & ~vsync_reg;
    assign in_end     = (state_reg == OVER) || (state_reg == WIN);

    // Restart out of an end screen takes priority over counting a coincident frame tick.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= 8'd0;
            game_run      <= 1'b0;
            snake_rst     <= 1'b0;
            hold_done     <= 1'b0;
        end else begin
            snake_rst <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_btn) begin
                        state_reg <= RESTART;
                        snake_rst <= 1'b1;
                    end
                end
                PLAY: begin
                    if (collision || win) begin
                        state_reg     <= collision ? OVER : WIN;
                        game_run      <= 1'b0;
                        frame_cnt_reg <= 8'd0;
                        hold_done     <= 1'b0;
                    end
                end
                OVER, WIN: begin
                    if (hold_done && start_btn) begin
                        state_reg <= RESTART;
                        snake_rst <= 1'b1;
                        hold_done <= 1'b0;
                    end else if (frame_tick && frame_cnt_reg != HOLD_MAX) begin
                        frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        hold_done     <= (frame_cnt_reg + 8'd1 == HOLD_MAX);
                    end
                end
                RESTART: begin
                    state_reg <= PLAY;
                    game_run  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    game_run  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_SCREEN_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt_reg;
    logic       blink_phase_reg;

    // Phase restarts high on every entry into an end screen.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg   <= 8'd0;
            blink_phase_reg <= 1'b0;
        end else if (state_reg == PLAY && (collision || win)) begin
            blink_cnt_reg   <= 8'd0;
            blink_phase_reg <= 1'b1;
        end else if (in_end && frame_tick) begin
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_reg   <= 8'd0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 8'd1;
            end
        end
    end

    assign blink_phase = blink_phase_reg;
`else
    assign blink_phase = 1'b1;
`endif

    // Overlays only move on frame boundaries; the two states are exclusive so the outputs are too.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            game_over <= 1'b0;
            victory   <= 1'b0;
        end else if (frame_tick) begin
            game_over <= (state_reg == OVER) && blink_phase && in_end;
            victory   <= (state_reg == WIN) && blink_phase && in_end;
        end
    end

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Randomised + directed bench for game_screen_ctrl; per-cycle expected outputs come from a
// frame-counting reference model and are checked by a separate monitor through a queue.
module tb_game_screen_ctrl;

    localparam int HOLD  = 3;
    localparam int BLINK = 2;
    localparam int FRAME = 7;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic vsync_in = 1'b0;
    logic start_btn = 1'b0;
    logic collision = 1'b0;
    logic win = 1'b0;
    logic game_run, game_over, victory, snake_rst, hold_done;

    game_screen_ctrl #(.HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start_btn(start_btn),
        .collision(collision), .win(win), .game_run(game_run), .game_over(game_over),
        .victory(victory), .snake_rst(snake_rst), .hold_done(hold_done)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic run;
        logic go;
        logic vic;
        logic srst;
        logic hold;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: mode names and an unsaturated count of frame ticks spent on the end screen.
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2, M_WIN = 3, M_RST = 4;
    int   m_mode = M_IDLE;
    int   m_ticks = 0;
    bit   m_vs = 0;
    bit   m_go = 0;
    bit   m_vic = 0;
    int   m_restarts = 0;

    function automatic bit phase_of(input int ticks);
`ifdef GAME_SCREEN_BLINK_EN
        return ((ticks / BLINK) % 2) == 0;
`else
        return 1'b1 | (ticks < 0);
`endif
    endfunction

    function automatic bit is_end(input int mode);
        return (mode == M_OVER) || (mode == M_WIN);
    endfunction

    always @(posedge pclk or posedge rst) begin
        out_t e;
        bit   ft;
        bit   hold_now;
        if (rst) begin
            m_mode  = M_IDLE;
            m_ticks = 0;
            m_vs    = 0;
            m_go    = 0;
            m_vic   = 0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            ft       = vsync_in && !m_vs;
            m_vs     = vsync_in;
            hold_now = is_end(m_mode) && (m_ticks >= HOLD);
            if (ft) begin
                m_go  = (m_mode == M_OVER) && phase_of(m_ticks);
                m_vic = (m_mode == M_WIN) && phase_of(m_ticks);
            end
            case (m_mode)
                M_IDLE: if (start_btn) m_mode = M_RST;
                M_PLAY: begin
                    if (collision) begin
                        m_mode = M_OVER; m_ticks = 0;
                    end else if (win) begin
                        m_mode = M_WIN; m_ticks = 0;
                    end
                end
                M_OVER, M_WIN: begin
                    if (hold_now && start_btn) m_mode = M_RST;
                    else if (ft) m_ticks++;
                end
                default: m_mode = M_PLAY;
            endcase
            if (m_mode == M_RST) m_restarts++;
            e.run  = (m_mode == M_PLAY);
            e.go   = m_go;
            e.vic  = m_vic;
            e.srst = (m_mode == M_RST);
            e.hold = is_end(m_mode) && (m_ticks >= HOLD);
            exp_q.push_back(e);
        end
    end

    // Monitor: one expected output vector per cycle, checked mid-cycle.
    always @(negedge pclk) begin
        out_t e;
        out_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{run: game_run, go: game_over, vic: victory, srst: snake_rst, hold: hold_done};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL outputs t=%0t act(run,go,vic,srst,hold)=%b req=%b", $time, a, e);
            end
            n_checks++;
            if (game_over === 1'b1 && victory === 1'b1) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL exclusive t=%0t act go=%b vic=%b req not both 1", $time, game_over, victory);
            end
        end
    end

    int vcnt = 0;

    task automatic cyc();
        @(posedge pclk);
        #2;
        vcnt++;
        vsync_in  = (vcnt % FRAME) < 3;
        collision = 1'b0;
        win       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        idle(3);
        rst = 1'b0;
        idle(10);
        $display("txn reset_idle restarts=%0d", m_restarts);

        cyc(); start_btn = 1'b1;
        cyc(); start_btn = 1'b0;
        idle(20);
        $display("txn start restarts=%0d", m_restarts);

        cyc(); collision = 1'b1;
        cyc(); start_btn = 1'b1;
        idle(60);
        start_btn = 1'b0;
        idle(10);
        $display("txn collision_restart restarts=%0d", m_restarts);

        cyc(); collision = 1'b1; win = 1'b1;
        idle(200 * FRAME);
        start_btn = 1'b1;
        idle(5);
        start_btn = 1'b0;
        idle(10);
        $display("txn collision_and_win restarts=%0d", m_restarts);

        cyc(); win = 1'b1; start_btn = 1'b1;
        idle(40);
        start_btn = 1'b0;
        idle(20);
        $display("txn win_hold restarts=%0d", m_restarts);

        cyc(); collision = 1'b1;
        idle(2 * FRAME);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(30);
        $display("txn reset_in_over restarts=%0d", m_restarts);

        for (int i = 0; i < 4000; i++) begin
            cyc();
            start_btn = ($urandom_range(0, 7) == 0);
            collision = ($urandom_range(0, 39) == 0);
            win       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 799) == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        rst = 1'b0;
        idle(5);
        $display("txn random restarts=%0d", m_restarts);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
